phase_sequencer: RTL

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer_pkg.sv | 38 +++
 rtl/phase_sequencer_if.sv | 27 ++
 rtl/phase_sequencer_wait_timer.sv | 32 +++
 rtl/phase_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: phase bit indices, state encoding
// and the default bus-wait limit.
package phase_sequencer_pkg;

    localparam int PH_F = 0;
    localparam int PH_R = 1;
    localparam int PH_X = 2;
    localparam int PH_M = 3;
    localparam int PH_W = 4;
    localparam int PH_N = 5;

    localparam int WAIT_MAX_DEFAULT = 15;

    typedef enum logic [2:0] {
        ST_F    = 3'd0,
        ST_R    = 3'd1,
        ST_X    = 3'd2,
        ST_M    = 3'd3,
        ST_W    = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    // One-hot phase vector for a state; HALT has no phase bit.
    function automatic logic [PH_N-1:0] phase_of(input state_t s);
        logic [PH_N-1:0] p;
        p = '0;
        case (s)
            ST_F:    p[PH_F] = 1'b1;
            ST_R:    p[PH_R] = 1'b1;
            ST_X:    p[PH_X] = 1'b1;
            ST_M:    p[PH_M] = 1'b1;
            ST_W:    p[PH_W] = 1'b1;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Memory handshake bundle between the phase sequencer (master) and the
// instruction/data memories (slave).
interface phase_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        dmem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack,
        output dmem_ack
    );

endinterface

// File: rtl/phase_sequencer_wait_timer.sv
// Counts cycles spent waiting on a memory ack; timeout flags that the count
// has reached WAIT_MAX.
module phase_sequencer_wait_timer
    import phase_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] cnt;

    assign timeout = (cnt == CNT_W'(WAIT_MAX));

    // Saturate at WAIT_MAX so the compare can never be skipped by wrapping.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !timeout) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle F/R/X/M/W instruction phase sequencer with memory-wait timeout.
// Define MEM_SKIP_EN to let non-memory instructions go straight from X to W.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    phase_sequencer_if.master    bus,
    input  logic [31:0]          pc,
    input  logic                 mem_op,
    input  logic                 halt,
    output logic [PH_N-1:0]      phase,
    output logic [31:0]          ir,
    output logic                 halted,
    output logic                 bus_err,
    output logic [31:0]          retired
);

    state_t state;
    state_t state_nxt;
    logic   ir_ld;
    logic   ret_inc;
    logic   err_set;
    logic   wait_en;
    logic   wait_clr;
    logic   tmo;

    phase_sequencer_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (wait_clr),
        .en      (wait_en),
        .timeout (tmo)
    );

    assign wait_clr      = (state_nxt != state);
    assign phase         = phase_of(state);
    assign halted        = (state == ST_HALT);
    assign bus.imem_addr = pc;
    // The request is held off while reset is asserted even though state is F.
    assign bus.imem_req  = n_rst && (state == ST_F);

    always_comb begin
        state_nxt = state;
        ir_ld     = 1'b0;
        ret_inc   = 1'b0;
        err_set   = 1'b0;
        wait_en   = 1'b0;
        case (state)
            ST_F: begin
                if (bus.imem_ack) begin
                    ir_ld     = 1'b1;
                    state_nxt = ST_R;
                end else begin
                    wait_en = 1'b1;
                    if (tmo) begin
                        err_set   = 1'b1;
                        state_nxt = ST_HALT;
                    end
                end
            end
            ST_R: state_nxt = ST_X;
            ST_X: begin
`ifdef MEM_SKIP_EN
                state_nxt = mem_op ? ST_M : ST_W;
`else
                state_nxt = ST_M;
`endif
            end
            ST_M: begin
                if (!mem_op || bus.dmem_ack) begin
                    state_nxt = ST_W;
                end else begin
                    wait_en = 1'b1;
                    if (tmo) begin
                        err_set   = 1'b1;
                        state_nxt = ST_HALT;
                    end
                end
            end
            ST_W: begin
                ret_inc   = 1'b1;
                state_nxt = halt ? ST_HALT : ST_F;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_F;
            ir      <= '0;
            retired <= '0;
            bus_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ir_ld) begin
                ir <= bus.imem_rdata;
            end
            if (ret_inc) begin
                retired <= retired + 32'd1;
            end
            if (err_set) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule
